register_rename_map: RTL and testbench

Full speculative register rename map for the rename stage: all logical-to-physical mappings in one block, with parametrised register counts and port counts. It renames up to REGIST_N destinations per cycle and returns each displaced (old) physical name for later release at commit. It keeps a committed (rollback) map updated by up to COMMIT_N retiring instructions and restores the speculative map from it on restart. It sits between decode and the scheduler/free-list.

---
 rtl/register_rename_map.sv | 148 ++++++++++++++
 tb/tb_register_rename_map.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_rename_map.sv
// Speculative + committed logical-to-physical register rename map with restart rollback.
// Optional single-snapshot checkpoint support is enabled by defining RENAME_MAP_CHECKPOINT_EN.
module register_rename_map #(
  parameter int LREG_W   = 5,
  parameter int PREG_W   = 6,
  parameter int REGIST_N = 2,
  parameter int COMMIT_N = 4,
  parameter int READ_N   = 4
) (
  input  logic                         iCLOCK,
  input  logic                         inRESET,
  input  logic                         iRESTART_VALID,
  input  logic                         iLOCK,
`ifdef RENAME_MAP_CHECKPOINT_EN
  input  logic                         iCHECKPOINT_SAVE,
  input  logic                         iCHECKPOINT_RESTORE,
`endif
  input  logic [REGIST_N-1:0]          iREGIST_VALID,
  input  logic [REGIST_N*LREG_W-1:0]   iREGIST_LREG,
  input  logic [REGIST_N*PREG_W-1:0]   iREGIST_PREG,
  output logic [REGIST_N-1:0]          oREGIST_OLD_VALID,
  output logic [REGIST_N*PREG_W-1:0]   oREGIST_OLD_PREG,
  input  logic [COMMIT_N-1:0]          iCOMMIT_VALID,
  input  logic [COMMIT_N*LREG_W-1:0]   iCOMMIT_LREG,
  input  logic [COMMIT_N*PREG_W-1:0]   iCOMMIT_PREG,
  input  logic [READ_N*LREG_W-1:0]     iREAD_LREG,
  output logic [READ_N*PREG_W-1:0]     oREAD_PREG,
  output logic                         oREADY
);

  localparam int LREG_N = 2 ** LREG_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t                     state;
  logic [PREG_W-1:0]          spec_map    [LREG_N];
  logic [PREG_W-1:0]          commit_map  [LREG_N];
  logic [PREG_W-1:0]          spec_next   [LREG_N];
  logic [PREG_W-1:0]          commit_next [LREG_N];
  logic [PREG_W-1:0]          ren_map     [LREG_N];
  logic [REGIST_N*PREG_W-1:0] old_preg_p0;
  logic [REGIST_N-1:0]        old_vld_p0;
  logic [REGIST_N*PREG_W-1:0] old_preg_p1;
  logic [REGIST_N-1:0]        old_vld_p1;
  logic                       restore;
  logic                       ren_en;

`ifdef RENAME_MAP_CHECKPOINT_EN
  logic [PREG_W-1:0]          snap_map    [LREG_N];
  assign restore = iCHECKPOINT_RESTORE;
`else
  assign restore = 1'b0;
`endif

  assign ren_en = (state == RUN) && !iLOCK && !iRESTART_VALID && !restore;

  // Stage p0: merge commits and renames, resolve displaced names
  always_comb begin
    commit_next = commit_map;
    for (int c = 0; c < COMMIT_N; c++) begin
      if (iCOMMIT_VALID[c])
        commit_next[iCOMMIT_LREG[c*LREG_W +: LREG_W]] = iCOMMIT_PREG[c*PREG_W +: PREG_W];
    end

    ren_map = spec_map;
    for (int k = 0; k < REGIST_N; k++) begin
      if (iREGIST_VALID[k])
        ren_map[iREGIST_LREG[k*LREG_W +: LREG_W]] = iREGIST_PREG[k*PREG_W +: PREG_W];
    end

    // Older in-group writers to the same lreg override the table; the last (youngest older) one wins.
    old_preg_p0 = '0;
    old_vld_p0  = '0;
    for (int k = 0; k < REGIST_N; k++) begin
      old_preg_p0[k*PREG_W +: PREG_W] = spec_map[iREGIST_LREG[k*LREG_W +: LREG_W]];
      for (int j = 0; j < REGIST_N; j++) begin
        if (j < k && iREGIST_VALID[j] &&
            iREGIST_LREG[j*LREG_W +: LREG_W] == iREGIST_LREG[k*LREG_W +: LREG_W])
          old_preg_p0[k*PREG_W +: PREG_W] = iREGIST_PREG[j*PREG_W +: PREG_W];
      end
      old_vld_p0[k] = ren_en && iREGIST_VALID[k];
    end

    if (iRESTART_VALID)
      spec_next = commit_next;
`ifdef RENAME_MAP_CHECKPOINT_EN
    else if (restore)
      spec_next = snap_map;
`endif
    else if (ren_en)
      spec_next = ren_map;
    else
      spec_next = spec_map;
  end

  // Stage p1: registered map state and old-name results
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= INIT;
      old_vld_p1  <= '0;
      old_preg_p1 <= '0;
      for (int i = 0; i < LREG_N; i++) begin
        spec_map[i]   <= '0;
        commit_map[i] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          state      <= RUN;
          old_vld_p1 <= '0;
          for (int i = 0; i < LREG_N; i++) begin
            spec_map[i]   <= PREG_W'(i);
            commit_map[i] <= PREG_W'(i);
          end
        end
        default: begin
          state       <= RUN;
          spec_map    <= spec_next;
          commit_map  <= commit_next;
          old_vld_p1  <= old_vld_p0;
          old_preg_p1 <= old_preg_p0;
        end
      endcase
    end
  end

`ifdef RENAME_MAP_CHECKPOINT_EN
  // A save in the same cycle as a restore is discarded so the snapshot survives.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < LREG_N; i++)
        snap_map[i] <= '0;
    end else if (state == RUN && iCHECKPOINT_SAVE && !iCHECKPOINT_RESTORE) begin
      snap_map <= spec_next;
    end
  end
`endif

  always_comb begin
    for (int r = 0; r < READ_N; r++)
      oREAD_PREG[r*PREG_W +: PREG_W] = spec_map[iREAD_LREG[r*LREG_W +: LREG_W]];
  end

  assign oREGIST_OLD_VALID = old_vld_p1;
  assign oREGIST_OLD_PREG  = old_preg_p1;
  assign oREADY            = (state == RUN);

endmodule

// File: tb/tb_register_rename_map.sv
// Randomized self-checking bench for register_rename_map against an array-based reference model.
// Checkpoint scenarios are exercised when RENAME_MAP_CHECKPOINT_EN is defined.
module tb_register_rename_map;

  localparam int LREG_W   = 5;
  localparam int PREG_W   = 6;
  localparam int REGIST_N = 2;
  localparam int COMMIT_N = 4;
  localparam int READ_N   = 4;
  localparam int LREG_N   = 2 ** LREG_W;

  logic                         iCLOCK = 1'b0;
  logic                         inRESET;
  logic                         iRESTART_VALID;
  logic                         iLOCK;
  logic                         iCHECKPOINT_SAVE;
  logic                         iCHECKPOINT_RESTORE;
  logic [REGIST_N-1:0]          iREGIST_VALID;
  logic [REGIST_N*LREG_W-1:0]   iREGIST_LREG;
  logic [REGIST_N*PREG_W-1:0]   iREGIST_PREG;
  logic [REGIST_N-1:0]          oREGIST_OLD_VALID;
  logic [REGIST_N*PREG_W-1:0]   oREGIST_OLD_PREG;
  logic [COMMIT_N-1:0]          iCOMMIT_VALID;
  logic [COMMIT_N*LREG_W-1:0]   iCOMMIT_LREG;
  logic [COMMIT_N*PREG_W-1:0]   iCOMMIT_PREG;
  logic [READ_N*LREG_W-1:0]     iREAD_LREG;
  logic [READ_N*PREG_W-1:0]     oREAD_PREG;
  logic                         oREADY;

  int total = 0;
  int bad   = 0;

  int spec_m [LREG_N];
  int comm_m [LREG_N];
  int snap_m [LREG_N];
  int ready_m;

  register_rename_map #(
    .LREG_W(LREG_W), .PREG_W(PREG_W), .REGIST_N(REGIST_N),
    .COMMIT_N(COMMIT_N), .READ_N(READ_N)
  ) dut (
    .iCLOCK(iCLOCK),
    .inRESET(inRESET),
    .iRESTART_VALID(iRESTART_VALID),
    .iLOCK(iLOCK),
`ifdef RENAME_MAP_CHECKPOINT_EN
    .iCHECKPOINT_SAVE(iCHECKPOINT_SAVE),
    .iCHECKPOINT_RESTORE(iCHECKPOINT_RESTORE),
`endif
    .iREGIST_VALID(iREGIST_VALID),
    .iREGIST_LREG(iREGIST_LREG),
    .iREGIST_PREG(iREGIST_PREG),
    .oREGIST_OLD_VALID(oREGIST_OLD_VALID),
    .oREGIST_OLD_PREG(oREGIST_OLD_PREG),
    .iCOMMIT_VALID(iCOMMIT_VALID),
    .iCOMMIT_LREG(iCOMMIT_LREG),
    .iCOMMIT_PREG(iCOMMIT_PREG),
    .iREAD_LREG(iREAD_LREG),
    .oREAD_PREG(oREAD_PREG),
    .oREADY(oREADY)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iRESTART_VALID      = 1'b0;
    iLOCK               = 1'b0;
    iCHECKPOINT_SAVE    = 1'b0;
    iCHECKPOINT_RESTORE = 1'b0;
    iREGIST_VALID       = '0;
    iREGIST_LREG        = '0;
    iREGIST_PREG        = '0;
    iCOMMIT_VALID       = '0;
    iCOMMIT_LREG        = '0;
    iCOMMIT_PREG        = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LREG_N; i++) begin
      spec_m[i] = 0;
      comm_m[i] = 0;
      snap_m[i] = 0;
    end
    ready_m = 0;
  endtask

  task automatic rd(input int l, output int p);
    iREAD_LREG[0 +: LREG_W] = LREG_W'(l);
    #1;
    p = int'(oREAD_PREG[0 +: PREG_W]);
  endtask

  // Advance one clock: predict from the current inputs, then compare the DUT afterwards.
  task automatic tick();
    int spec_n [LREG_N];
    int comm_n [LREG_N];
    int old_e  [REGIST_N];
    int ov_e   [REGIST_N];
    int lr, lk, p;
    bit ren_ok, rst_in, res_in;
    rst_in = iRESTART_VALID;
`ifdef RENAME_MAP_CHECKPOINT_EN
    res_in = iCHECKPOINT_RESTORE;
`else
    res_in = 1'b0;
`endif
    for (int k = 0; k < REGIST_N; k++) begin
      old_e[k] = 0;
      ov_e[k]  = 0;
    end
    if (ready_m == 0) begin
      for (int i = 0; i < LREG_N; i++) begin
        spec_n[i] = i;
        comm_n[i] = i;
      end
    end else begin
      comm_n = comm_m;
      for (int c = 0; c < COMMIT_N; c++)
        if (iCOMMIT_VALID[c]) comm_n[iCOMMIT_LREG[c*LREG_W +: LREG_W]] = int'(iCOMMIT_PREG[c*PREG_W +: PREG_W]);
      ren_ok = !iLOCK && !rst_in && !res_in;
      for (int k = 0; k < REGIST_N; k++) begin
        lk = int'(iREGIST_LREG[k*LREG_W +: LREG_W]);
        old_e[k] = spec_m[lk];
        for (int j = k - 1; j >= 0; j--) begin
          if (iREGIST_VALID[j] && int'(iREGIST_LREG[j*LREG_W +: LREG_W]) == lk) begin
            old_e[k] = int'(iREGIST_PREG[j*PREG_W +: PREG_W]);
            break;
          end
        end
        ov_e[k] = (ren_ok && iREGIST_VALID[k]) ? 1 : 0;
      end
      if (rst_in) spec_n = comm_n;
      else if (res_in) spec_n = snap_m;
      else begin
        spec_n = spec_m;
        if (ren_ok)
          for (int i = 0; i < LREG_N; i++)
            for (int k = REGIST_N - 1; k >= 0; k--)
              if (iREGIST_VALID[k] && int'(iREGIST_LREG[k*LREG_W +: LREG_W]) == i) begin
                spec_n[i] = int'(iREGIST_PREG[k*PREG_W +: PREG_W]);
                break;
              end
      end
`ifdef RENAME_MAP_CHECKPOINT_EN
      if (iCHECKPOINT_SAVE && !res_in) snap_m = spec_n;
`endif
    end
    @(posedge iCLOCK);
    #1;
    spec_m  = spec_n;
    comm_m  = comm_n;
    ready_m = 1;
    check("ready", oREADY, 1);
    for (int k = 0; k < REGIST_N; k++) begin
      check("old_vld", oREGIST_OLD_VALID[k], ov_e[k]);
      if (ov_e[k] != 0) check("old_preg", oREGIST_OLD_PREG[k*PREG_W +: PREG_W], old_e[k]);
    end
    for (int r = 0; r < READ_N; r++) iREAD_LREG[r*LREG_W +: LREG_W] = LREG_W'($urandom_range(LREG_N - 1));
    #1;
    for (int r = 0; r < READ_N; r++) begin
      lr = int'(iREAD_LREG[r*LREG_W +: LREG_W]);
      p  = int'(oREAD_PREG[r*PREG_W +: PREG_W]);
      check("read", p, spec_m[lr]);
    end
  endtask

  task automatic reset_checks();
    int p;
    check("rst_ready", oREADY, 0);
    check("rst_old_vld", oREGIST_OLD_VALID, 0);
    check("rst_old_preg", oREGIST_OLD_PREG, 0);
    rd(7, p);
    check("rst_map7", p, 0);
    inRESET = 1'b1;
    #1;
    check("init_ready", oREADY, 0);
    tick();
    rd(7, p);
    check("map7", p, 7);
    rd(31, p);
    check("map31", p, 31);
  endtask

  task automatic ren(input int v, input int l0, input int p0, input int l1, input int p1);
    iREGIST_VALID = REGIST_N'(v);
    iREGIST_LREG  = {LREG_W'(l1), LREG_W'(l0)};
    iREGIST_PREG  = {PREG_W'(p1), PREG_W'(p0)};
  endtask

  initial begin
    int p;
    idle();
    iREAD_LREG = '0;
    inRESET    = 1'b0;
    model_reset();
    repeat (2) @(posedge iCLOCK);
    #1;
    reset_checks();

    ren(3, 3, 40, 3, 41);
    tick();
    idle();
    check("grp_old0", oREGIST_OLD_PREG[0 +: PREG_W], 3);
    check("grp_old1", oREGIST_OLD_PREG[PREG_W +: PREG_W], 40);
    check("grp_vld", oREGIST_OLD_VALID, 3);
    rd(3, p);
    check("grp_map3", p, 41);

    ren(1, 5, 50, 0, 0);
    iLOCK = 1'b1;
    tick();
    check("lock_vld", oREGIST_OLD_VALID, 0);
    rd(5, p);
    check("lock_map5", p, 5);
    iLOCK = 1'b0;
    tick();
    idle();
    rd(5, p);
    check("unlock_map5", p, 50);

    ren(1, 2, 33, 0, 0);
    tick();
    ren(1, 2, 34, 0, 0);
    tick();
    ren(1, 2, 35, 0, 0);
    iCOMMIT_VALID  = 4'b0001;
    iCOMMIT_LREG   = '0;
    iCOMMIT_LREG[0 +: LREG_W] = 5'd2;
    iCOMMIT_PREG   = '0;
    iCOMMIT_PREG[0 +: PREG_W] = 6'd33;
    iRESTART_VALID = 1'b1;
    tick();
    idle();
    rd(2, p);
    check("restart_map2", p, 33);
    check("restart_vld", oREGIST_OLD_VALID, 0);

    iCOMMIT_VALID = 4'b1001;
    iCOMMIT_LREG[0 +: LREG_W]        = 5'd9;
    iCOMMIT_LREG[3*LREG_W +: LREG_W] = 5'd9;
    iCOMMIT_PREG[0 +: PREG_W]        = 6'd20;
    iCOMMIT_PREG[3*PREG_W +: PREG_W] = 6'd21;
    iRESTART_VALID = 1'b1;
    tick();
    idle();
    rd(9, p);
    check("dup_commit_map9", p, 21);

`ifdef RENAME_MAP_CHECKPOINT_EN
    ren(1, 4, 44, 0, 0);
    iCHECKPOINT_SAVE = 1'b1;
    tick();
    idle();
    ren(1, 4, 45, 0, 0);
    tick();
    idle();
    iCHECKPOINT_RESTORE = 1'b1;
    iCHECKPOINT_SAVE    = 1'b1;
    ren(1, 4, 46, 0, 0);
    tick();
    idle();
    rd(4, p);
    check("ckpt_map4", p, 44);
`endif

    for (int n = 0; n < 400; n++) begin
      iREGIST_VALID  = REGIST_N'($urandom);
      iCOMMIT_VALID  = COMMIT_N'($urandom);
      iLOCK          = ($urandom_range(7) == 0);
      iRESTART_VALID = ($urandom_range(15) == 0);
`ifdef RENAME_MAP_CHECKPOINT_EN
      iCHECKPOINT_SAVE    = ($urandom_range(7) == 0);
      iCHECKPOINT_RESTORE = ($urandom_range(11) == 0);
`endif
      for (int k = 0; k < REGIST_N; k++) begin
        iREGIST_LREG[k*LREG_W +: LREG_W] = LREG_W'($urandom_range(7));
        iREGIST_PREG[k*PREG_W +: PREG_W] = PREG_W'($urandom);
      end
      for (int c = 0; c < COMMIT_N; c++) begin
        iCOMMIT_LREG[c*LREG_W +: LREG_W] = LREG_W'($urandom_range(7));
        iCOMMIT_PREG[c*PREG_W +: PREG_W] = PREG_W'($urandom);
      end
      tick();
    end
    idle();

    inRESET = 1'b0;
    model_reset();
    #1;
    reset_checks();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
